// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: one-at-a-time read/write initiator for a byte memory port.
// Optional write read-back check enabled by defining WRITE_VERIFY_EN.
module mem_access_ctrl #(
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 8,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_wr,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              verify_err,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(RD_LATENCY + 1);
   localparam logic [CNT_W-1:0] LAT_LD = CNT_W'(RD_LATENCY);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_RESP  = 3'd3,
      ST_VRD   = 3'd4
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_wr;
   logic             w_expire;

`ifdef WRITE_VERIFY_EN
   logic             r_verify_err;
   logic             w_verify_bad;

   // A verify read that returns something other than the written byte.
   assign w_verify_bad = r_wr && (mem_rdata != mem_wdata);
   assign verify_err   = r_verify_err;
`else
   assign verify_err   = 1'b0;
`endif

   // Read data is due at the edge where the latency counter runs out.
   assign w_expire = (r_cnt == CNT_ONE);

   // Control FSM; every output toggles only here so all are registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_wr      <= 1'b0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_wr    <= 1'b0;
         rsp_rdata <= '0;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
`ifdef WRITE_VERIFY_EN
         r_verify_err <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_wr      <= req_wr;
                  mem_addr  <= req_addr;
                  mem_wdata <= req_wdata;
                  mem_wr    <= req_wr;
                  mem_rd    <= ~req_wr;
                  req_ready <= 1'b0;
                  r_state   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               mem_rd <= 1'b0;
               mem_wr <= 1'b0;
               if (r_wr) begin
`ifdef WRITE_VERIFY_EN
                  mem_rd  <= 1'b1;
                  r_state <= ST_VRD;
`else
                  rsp_valid <= 1'b1;
                  rsp_wr    <= 1'b1;
                  rsp_rdata <= mem_wdata;
                  r_state   <= ST_RESP;
`endif
               end else begin
                  r_cnt   <= LAT_LD;
                  r_state <= ST_WAIT;
               end
            end
`ifdef WRITE_VERIFY_EN
            ST_VRD: begin
               mem_rd  <= 1'b0;
               r_cnt   <= LAT_LD;
               r_state <= ST_WAIT;
            end
`endif
            ST_WAIT: begin
               if (w_expire) begin
                  rsp_rdata <= mem_rdata;
                  rsp_wr    <= r_wr;
                  rsp_valid <= 1'b1;
                  r_cnt     <= '0;
                  r_state   <= ST_RESP;
`ifdef WRITE_VERIFY_EN
                  if (w_verify_bad) r_verify_err <= 1'b1;
`endif
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  r_state   <= ST_IDLE;
               end
            end
            default: begin
               mem_rd    <= 1'b0;
               mem_wr    <= 1'b0;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
